// File: rtl/multi_operand_adder_with_fifos.sv
// Buffers n_in independent operand streams in per-channel circular FIFOs and emits
// the unsigned sum of one head entry per channel on a registered output (wrap or saturate).
module multi_operand_adder_with_fifos #(
  parameter int width    = 4,
  parameter int depth    = 4,
  parameter int n_in     = 3,
  parameter int saturate = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [n_in-1:0]         in_valid,
  output logic [n_in-1:0]         in_ready,
  input  logic [n_in*width-1:0]   in_data,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [width-1:0]        sum_data,
  output logic                    sum_overflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam int sw = width + $clog2(n_in);
  localparam logic [cw-1:0] full_count = cw'(depth);
  localparam logic [sw-1:0] max_val = {{(sw - width){1'b0}}, {width{1'b1}}};

  // Handshake: a beat moves on a posedge where valid & ready are both high; valid never
  // waits on ready, and in_ready is a function of registered FIFO counts only.

  logic [width-1:0] mem    [n_in][depth];
  logic [aw-1:0]    wr_ptr [n_in];
  logic [aw-1:0]    rd_ptr [n_in];
  logic [cw-1:0]    count  [n_in];

  logic [n_in-1:0]  push;
  logic [n_in-1:0]  non_empty;
  logic             fire;
  logic [sw-1:0]    total;
  logic             total_ovf;
  logic [width-1:0] sum_next;

  always_comb begin
    in_ready  = '0;
    push      = '0;
    non_empty = '0;
    for (int i = 0; i < n_in; i++) begin
      in_ready[i]  = ~rst & (count[i] != full_count);
      push[i]      = in_valid[i] & in_ready[i];
      non_empty[i] = (count[i] != '0);
    end
    fire = (&non_empty) & (~sum_valid | sum_ready);
  end

  // Full-precision sum of every FIFO head; sw bits cannot overflow for n_in operands.
  always_comb begin
    total = '0;
    for (int i = 0; i < n_in; i++) begin
      total = total + sw'(mem[i][rd_ptr[i]]);
    end
    total_ovf = (total > max_val);
    if ((saturate != 0) && total_ovf) begin
      sum_next = '1;
    end else begin
      sum_next = total[width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < n_in; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= in_data[i*width +: width];
      end
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < n_in; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < n_in; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (fire)    rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !fire) begin
          count[i] <= count[i] + 1'b1;
        end else if (!push[i] && fire) begin
          count[i] <= count[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_valid    <= 1'b0;
      sum_data     <= '0;
      sum_overflow <= 1'b0;
    end else if (fire) begin
      sum_valid    <= 1'b1;
      sum_data     <= sum_next;
      sum_overflow <= total_ovf;
    end else if (sum_ready) begin
      sum_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_operand_adder_with_fifos.sv
// Bench for multi_operand_adder_with_fifos: a wrapping and a saturating instance share
// the same stimulus; a monitor checks both against a queue of expected results.
module tb_multi_operand_adder_with_fifos;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int D  = 4;
  localparam int EW = 2*W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           sum_ready;
  logic [N-1:0]   in_ready_w, in_ready_s;
  logic           sum_valid_w, sum_valid_s;
  logic [W-1:0]   sum_data_w, sum_data_s;
  logic           sum_overflow_w, sum_overflow_s;

  multi_operand_adder_with_fifos #(.width(W), .depth(D), .n_in(N), .saturate(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .sum_valid(sum_valid_w), .sum_ready(sum_ready), .sum_data(sum_data_w),
    .sum_overflow(sum_overflow_w));

  multi_operand_adder_with_fifos #(.width(W), .depth(D), .n_in(N), .saturate(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .sum_valid(sum_valid_s), .sum_ready(sum_ready), .sum_data(sum_data_s),
    .sum_overflow(sum_overflow_s));

  int checks = 0;
  int errors = 0;

  // scoreboard state: {overflow, wrapped sum, saturated sum}
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  drv_q[N][$];
  int            out_cyc_q[$];
  int            out_cnt = 0;
  int            acc_cnt[N];
  logic [N-1:0]  ch_en = '1;
  logic          rand_mode = 1'b0;
  logic          sr_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic enqueue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] exp_wrap, input logic [W-1:0] exp_sat,
                         input logic exp_ovf);
    drv_q[0].push_back(a);
    drv_q[1].push_back(b);
    drv_q[2].push_back(c);
    exp_q.push_back({exp_ovf, exp_wrap, exp_sat});
  endtask

  function automatic int pending();
    return exp_q.size() + drv_q[0].size() + drv_q[1].size() + drv_q[2].size();
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, pending(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Single process owns in_valid / in_data / sum_ready; a channel's operand leaves its
  // queue only after the posedge at which the handshake completed.
  initial begin
    logic [N-1:0] xfer;
    in_valid  = '0;
    in_data   = '0;
    sum_ready = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) xfer[i] = !rst && in_valid[i] && in_ready_w[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (xfer[i]) void'(drv_q[i].pop_front());
        if (ch_en[i] && drv_q[i].size() > 0) begin
          in_valid[i] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
          in_data[i*W +: W] = drv_q[i][0];
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      sum_ready = rand_mode ? 1'($urandom_range(0, 1)) : sr_hold;
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      for (int i = 0; i < N; i++) if (in_valid[i] && in_ready_w[i]) acc_cnt[i]++;
      if (sum_valid_w && sum_ready) begin
        out_cnt++;
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got sum %0h with nothing expected", sum_data_w);
        end else begin
          e = exp_q.pop_front();
          check("sum_data_wrap", sum_data_w, e[2*W-1:W]);
          check("sum_data_sat", sum_data_s, e[W-1:0]);
          check("overflow_wrap", sum_overflow_w, e[2*W]);
          check("overflow_sat", sum_overflow_s, e[2*W]);
          check("sum_valid_sat", sum_valid_s, 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0[N];
    int o0;
    int k;
    logic [W-1:0] held;
    logic [W-1:0] ra, rb, rc;
    logic [5:0] s;

    for (int i = 0; i < N; i++) acc_cnt[i] = 0;

    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready_w, 0);
    check("rst_sum_valid", sum_valid_w, 0);
    check("rst_sum_data", sum_data_w, 0);
    check("rst_sum_overflow", sum_overflow_w, 0);
    check("rst_sum_data_sat", sum_data_s, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready_w, 3'b111);

    // back-to-back with latency
    sr_hold = 1'b1;
    repeat (2) @(negedge clk);
    out_cyc_q.delete();
    k = cyc;
    enqueue(3, 4, 5, 4'hC, 4'hC, 1'b0);
    enqueue(1, 1, 1, 4'h3, 4'h3, 1'b0);
    wait_drain("b2b_drained", 50);
    check("b2b_out_count", out_cyc_q.size(), 2);
    if (out_cyc_q.size() == 2) begin
      check("b2b_first_latency", out_cyc_q[0] - k, 3);
      check("b2b_second_latency", out_cyc_q[1] - k, 4);
    end

    // overflow boundaries
    enqueue(9, 8, 7, 4'h8, 4'hF, 1'b1);
    enqueue(5, 5, 5, 4'hF, 4'hF, 1'b0);
    enqueue(15, 15, 15, 4'hD, 4'hF, 1'b1);
    wait_drain("ovf_drained", 50);

    // starved channel 2
    ch_en = 3'b011;
    for (int i = 0; i < N; i++) a0[i] = acc_cnt[i];
    o0 = out_cnt;
    enqueue(1, 2, 3, 4'h6, 4'h6, 1'b0);
    enqueue(4, 5, 6, 4'hF, 4'hF, 1'b0);
    enqueue(0, 0, 0, 4'h0, 4'h0, 1'b0);
    enqueue(15, 15, 15, 4'hD, 4'hF, 1'b1);
    enqueue(8, 8, 0, 4'h0, 4'hF, 1'b1);
    enqueue(2, 2, 2, 4'h6, 4'h6, 1'b0);
    repeat (12) @(negedge clk);
    check("starve_acc_ch0", acc_cnt[0] - a0[0], 4);
    check("starve_acc_ch1", acc_cnt[1] - a0[1], 4);
    check("starve_acc_ch2", acc_cnt[2] - a0[2], 0);
    check("starve_in_ready", in_ready_w, 3'b100);
    check("starve_sum_valid", sum_valid_w, 0);
    check("starve_no_output", out_cnt - o0, 0);
    ch_en = 3'b111;
    wait_drain("starve_drained", 80);
    check("starve_out_count", out_cnt - o0, 6);
    check("starve_acc_ch2_total", acc_cnt[2] - a0[2], 6);

    // full backpressure: depth+1 accepts per channel
    sr_hold = 1'b0;
    for (int i = 0; i < N; i++) a0[i] = acc_cnt[i];
    enqueue(1, 0, 0, 4'h1, 4'h1, 1'b0);
    enqueue(2, 0, 0, 4'h2, 4'h2, 1'b0);
    enqueue(3, 1, 0, 4'h4, 4'h4, 1'b0);
    enqueue(4, 4, 4, 4'hC, 4'hC, 1'b0);
    enqueue(15, 1, 0, 4'h0, 4'hF, 1'b1);
    enqueue(7, 7, 0, 4'hE, 4'hE, 1'b0);
    enqueue(0, 0, 0, 4'h0, 4'h0, 1'b0);
    repeat (14) @(negedge clk);
    for (int i = 0; i < N; i++) check("bp_accepts", acc_cnt[i] - a0[i], D + 1);
    check("bp_in_ready", in_ready_w, 0);
    check("bp_sum_valid", sum_valid_w, 1);
    check("bp_first_data", sum_data_w, 4'h1);
    held = sum_data_w;
    repeat (3) @(negedge clk);
    check("bp_data_stable", sum_data_w, held);
    out_cyc_q.delete();
    sr_hold = 1'b1;
    wait_drain("bp_drained", 80);
    check("bp_out_count", out_cyc_q.size(), 7);
    if (out_cyc_q.size() >= 5) check("bp_consecutive", out_cyc_q[4] - out_cyc_q[0], 4);

    // reset mid-operation
    sr_hold = 1'b0;
    enqueue(1, 1, 1, 4'h3, 4'h3, 1'b0);
    enqueue(2, 2, 2, 4'h6, 4'h6, 1'b0);
    enqueue(3, 3, 3, 4'h9, 4'h9, 1'b0);
    enqueue(4, 4, 4, 4'hC, 4'hC, 1'b0);
    repeat (8) @(negedge clk);
    check("pre_rst_sum_valid", sum_valid_w, 1);
    @(posedge clk); #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", in_ready_w, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("after_rst_sum_valid", sum_valid_w, 0);
    check("after_rst_sum_valid_sat", sum_valid_s, 0);
    check("after_rst_in_ready", in_ready_w, 3'b111);
    o0 = out_cnt;
    sr_hold = 1'b1;
    enqueue(2, 3, 4, 4'h9, 4'h9, 1'b0);
    enqueue(6, 6, 6, 4'h2, 4'hF, 1'b1);
    wait_drain("rst_drained", 50);
    check("rst_out_count", out_cnt - o0, 2);

    // random traffic
    for (int i = 0; i < N; i++) a0[i] = acc_cnt[i];
    o0 = out_cnt;
    rand_mode = 1'b1;
    for (int n = 0; n < 100; n++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      rc = W'($urandom_range(0, 15));
      s  = 6'(ra) + 6'(rb) + 6'(rc);
      enqueue(ra, rb, rc, s[W-1:0], (s > 6'd15) ? 4'hF : s[W-1:0], s > 6'd15);
    end
    wait_drain("rand_drained", 4000);
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) check("rand_accepts", acc_cnt[i] - a0[i], 100);
    check("rand_out_count", out_cnt - o0, 100);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_operand_adder_with_fifos.md
Name: multi_operand_adder_with_fifos

Overview:
Generalised successor to the two-operand flow-controlled adder. It accepts `n_in` independent valid/ready operand streams and buffers each one in its own FIFO of `depth` entries. When every FIFO has an entry, it pops one from each and emits their unsigned sum on a registered valid/ready output. It also flags overflow and can optionally saturate. It sits between independent producers and one consumer in the streaming datapath.

Parameters:
- width, 4, operand and result width in bits.
- depth, 4, entries per input FIFO; power of two, at least 2.
- n_in, 3, number of operand channels; 2 to 8.
- saturate, 0, overflow handling: 0 wraps modulo 2^width, 1 clamps to 2^width-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  n_in  per-channel valid.
- in_ready  output  n_in  per-channel ready.
- in_data  input  n_in*width  channel i occupies bits [i*width +: width].
- sum_valid  output  1  result valid.
- sum_ready  input  1  downstream ready.
- sum_data  output  width  result (wrapped or saturated).
- sum_overflow  output  1  true sum exceeded 2^width-1; qualified by sum_valid.

Behaviour:
- Reset: clk and rst are as stated above. While rst is high and on the following edge:
  - all FIFOs are emptied and read/write pointers cleared;
  - sum_valid=0, sum_data=0, sum_overflow=0;
  - in_ready forced to 0 while rst is high.
- Reset mid-operation discards all buffered operands and any pending result. No output transfer completes on the reset edge.
- Channel i transfer: in_valid[i] & in_ready[i] at a posedge pushes in_data[i] into FIFO i.
- in_ready[i] = ~rst & (count_i != depth).
  - It depends only on registered state; there is no combinational path from sum_ready or in_valid.
  - A full FIFO therefore shows in_ready=0 even in a cycle where it is popped.
- Each FIFO is a circular buffer:
  - pointers wrap at depth;
  - count is (clog2(depth)+1) bits;
  - simultaneous push and pop leaves count unchanged;
  - push while full is impossible by construction;
  - pop while empty never occurs.
- Fire condition: all FIFOs non-empty AND (~sum_valid | sum_ready).
- On fire at a posedge:
  - pop head of every FIFO simultaneously;
  - compute the full sum S in width+clog2(n_in) bits;
  - load sum_data: S[width-1:0] if saturate=0, else (S > 2^width-1 ? 2^width-1 : S);
  - load sum_overflow = (S > 2^width-1);
  - set sum_valid=1.
- If sum_valid & sum_ready and no fire: sum_valid goes to 0. sum_data and sum_overflow hold their last values.
- While sum_valid & ~sum_ready, sum_data and sum_overflow are stable and no pop occurs.
- Latency:
  - an operand set completing at posedge t (last channel written) yields sum_valid=1 after posedge t+1;
  - minimum is 2 cycles from the accept edge to the output transfer edge.
- Throughput: one result per cycle sustained when all channels are valid and sum_ready=1.
- Capacity under full backpressure: each channel accepts exactly depth+1 operands (depth in its FIFO, 1 consumed into the output register) before in_ready drops.
- Channels are independent. A starved channel does not block others from filling their FIFOs, only from producing sums.
- Ordering: the k-th result equals the sum of the k-th accepted operand of each channel.

Test Plan:
- Back-to-back (width=4, n_in=3, depth=4): all in_valid=1, sum_ready=1, operands 3,4,5 then 1,1,1 -> sum_data 0xC then 0x3, sum_overflow=0. One result per cycle after a 2-cycle fill.
- Overflow: operands 9,8,7 (S=24):
  - saturate=0 -> sum_data=0x8, sum_overflow=1;
  - saturate=1 -> sum_data=0xF, sum_overflow=1;
  - operands 5,5,5 -> 0xF, sum_overflow=0 in both modes.
- Starved channel: channels 0 and 1 always valid, channel 2 idle -> exactly 4 accepts each, then in_ready[0]=in_ready[1]=0 and sum_valid stays 0. Enable channel 2 -> 4 results in order, then all channels resume.
- Backpressure: sum_ready=0, all valid -> exactly 5 accepts per channel. The first result stays on sum_data unchanged. Raise sum_ready -> 5 results in order over 5 consecutive cycles.
- Reset mid-operation: with 3 entries in each FIFO and sum_valid=1, assert rst for 1 cycle -> sum_valid=0, in_ready=0 during rst, then in_ready all 1. The next results use only post-reset operands.
- Random: random in_valid, sum_ready, and data for 100 transfers per channel with a queue-per-channel scoreboard. Every sum and overflow flag must match, and final transfer counts must be equal on all channels and the output.
